// File: rtl/lsu_bus.sv
// Multi-cycle load/store unit: accepts one EXU request, runs it over a
// request/response memory bus with byte strobes, returns extended data or an error.
module lsu_bus #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_ren,
  input  logic              in_wen,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata,
  input  logic              mem_resp_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_nx;
  logic [2:0]        f3_q;
  logic [OFS_W-1:0]  ofs_q;
  logic [OFS_W-1:0]  in_ofs;
  logic              f3_ok, misal, noop, bad;
  logic [7:0]        mask8;
  logic [NB-1:0]     strb;
  logic [XLEN-1:0]   wdata_sh;
  logic [XLEN-1:0]   rdata_sh, rdata_ext;

  assign in_ofs = in_addr[OFS_W-1:0];

  // Request decode, evaluated on the accept cycle from the live inputs.
  always_comb begin
    f3_ok = 1'b0;
    if (in_ren) begin
      case (in_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        3'b110, 3'b011:                         f3_ok = (XLEN == 64);
        default:                                f3_ok = 1'b0;
      endcase
    end else begin
      case (in_funct3)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        3'b011:                 f3_ok = (XLEN == 64);
        default:                f3_ok = 1'b0;
      endcase
    end
    case (in_funct3[1:0])
      2'd1:    misal = in_addr[0];
      2'd2:    misal = |in_addr[1:0];
      2'd3:    misal = |in_addr[2:0];
      default: misal = 1'b0;
    endcase
    case (in_funct3[1:0])
      2'd0:    mask8 = 8'h01;
      2'd1:    mask8 = 8'h03;
      2'd2:    mask8 = 8'h0F;
      default: mask8 = 8'hFF;
    endcase
    noop     = !in_ren && !in_wen;
    bad      = (in_ren && in_wen) || !f3_ok || misal;
    strb     = NB'(mask8) << in_ofs;
    wdata_sh = in_wdata << {in_ofs, 3'b000};
  end

  always_comb begin
    rdata_sh = mem_resp_rdata >> {ofs_q, 3'b000};
    case (f3_q)
      3'b000:  rdata_ext = XLEN'($signed(rdata_sh[7:0]));
      3'b001:  rdata_ext = XLEN'($signed(rdata_sh[15:0]));
      3'b010:  rdata_ext = XLEN'($signed(rdata_sh[31:0]));
      3'b100:  rdata_ext = XLEN'(rdata_sh[7:0]);
      3'b101:  rdata_ext = XLEN'(rdata_sh[15:0]);
      3'b110:  rdata_ext = XLEN'(rdata_sh[31:0]);
      default: rdata_ext = rdata_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = (noop || bad) ? DONE : REQ;
      REQ:  if (mem_req_ready) state_nx = WAIT;
      WAIT: if (mem_resp_valid) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign out_valid     = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q          <= '0;
      ofs_q         <= '0;
      out_rdata     <= '0;
      out_err       <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          out_rdata <= '0;
          out_err   <= !noop && bad;
          if (!noop && !bad) begin
            f3_q          <= in_funct3;
            ofs_q         <= in_ofs;
            mem_req_we    <= in_wen;
            mem_req_addr  <= {in_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            mem_req_wdata <= in_wen ? wdata_sh : '0;
            mem_req_wstrb <= in_wen ? strb : '0;
          end
        end
        WAIT: if (mem_resp_valid) begin
          out_err   <= mem_resp_err;
          out_rdata <= (!mem_req_we && !mem_resp_err) ? rdata_ext : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: RV32 instance for the main scenarios, RV64 instance
// for doubleword and lwu loads.
module tb_lsu_bus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned total = 0;
  int unsigned bad = 0;

  // RV32 instance
  logic        in_valid = 0, in_ren = 0, in_wen = 0, out_ready = 0;
  logic [2:0]  in_funct3 = 0;
  logic [31:0] in_addr = 0, in_wdata = 0;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_rdata;
  logic        mem_req_valid, mem_req_we;
  logic        mem_req_ready = 0, mem_resp_valid = 0, mem_resp_err = 0;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata = 0;
  logic [3:0]  mem_req_wstrb;

  // RV64 instance
  logic        w_in_valid = 0, w_in_ren = 0, w_in_wen = 0, w_out_ready = 0;
  logic [2:0]  w_in_funct3 = 0;
  logic [31:0] w_in_addr = 0;
  logic [63:0] w_in_wdata = 0;
  logic        w_in_ready, w_out_valid, w_out_err;
  logic [63:0] w_out_rdata;
  logic        w_mem_req_valid, w_mem_req_we;
  logic        w_mem_req_ready = 0, w_mem_resp_valid = 0, w_mem_resp_err = 0;
  logic [31:0] w_mem_req_addr;
  logic [63:0] w_mem_req_wdata, w_mem_resp_rdata = 0;
  logic [7:0]  w_mem_req_wstrb;

  lsu_bus #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
  );

  lsu_bus #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_ren(w_in_ren), .in_wen(w_in_wen),
    .in_funct3(w_in_funct3), .in_addr(w_in_addr), .in_wdata(w_in_wdata),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_rdata(w_out_rdata), .out_err(w_out_err),
    .mem_req_valid(w_mem_req_valid), .mem_req_ready(w_mem_req_ready), .mem_req_we(w_mem_req_we),
    .mem_req_addr(w_mem_req_addr), .mem_req_wdata(w_mem_req_wdata), .mem_req_wstrb(w_mem_req_wstrb),
    .mem_resp_valid(w_mem_resp_valid), .mem_resp_rdata(w_mem_resp_rdata), .mem_resp_err(w_mem_resp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_rdata !== 32'h0 || out_err !== 1'b0) begin bad++; $display("FAIL reset_out got=%h/%b want=0/0", out_rdata, out_err); end
    total++; if (mem_req_valid !== 1'b0 || mem_req_we !== 1'b0) begin bad++; $display("FAIL reset_req got=%b/%b want=0/0", mem_req_valid, mem_req_we); end
    total++; if (mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0 || mem_req_wstrb !== 4'h0) begin
      bad++; $display("FAIL reset_payload got=%h/%h/%b want=0/0/0000", mem_req_addr, mem_req_wdata, mem_req_wstrb); end
  endtask

  task automatic test_load_byte();
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h80FF_1234;
    in_valid = 1; in_ren = 1; in_wen = 0; in_funct3 = 3'b000; in_addr = 32'h8000_0003;
    tick();
    in_valid = 0; in_ren = 0;
    total++; if (mem_req_valid !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL lb_c1 got req=%b ov=%b want 1/0", mem_req_valid, out_valid); end
    total++; if (mem_req_addr !== 32'h8000_0000 || mem_req_wstrb !== 4'b0000 || mem_req_we !== 1'b0) begin
      bad++; $display("FAIL lb_req got=%h/%b/%b want=80000000/0000/0", mem_req_addr, mem_req_wstrb, mem_req_we); end
    tick();
    total++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL lb_c2 got ov=%b req=%b want 0/0", out_valid, mem_req_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lb_latency got=%b want=1", out_valid); end
    total++; if (out_rdata !== 32'hFFFF_FF80 || out_err !== 1'b0) begin bad++; $display("FAIL lb_rdata got=%h/%b want=ffffff80/0", out_rdata, out_err); end
    mem_req_ready = 0; mem_resp_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL lb_release got ir=%b ov=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_store_half();
    mem_req_ready = 1;
    in_valid = 1; in_wen = 1; in_ren = 0; in_funct3 = 3'b001; in_addr = 32'h8000_0002; in_wdata = 32'h1234_ABCD;
    tick();
    in_valid = 0; in_wen = 0;
    total++; if (mem_req_wdata !== 32'hABCD_0000 || mem_req_wstrb !== 4'b1100) begin
      bad++; $display("FAIL sh_payload got=%h/%b want=abcd0000/1100", mem_req_wdata, mem_req_wstrb); end
    total++; if (mem_req_we !== 1'b1 || mem_req_addr !== 32'h8000_0000 || mem_req_valid !== 1'b1) begin
      bad++; $display("FAIL sh_req got we=%b a=%h v=%b want 1/80000000/1", mem_req_we, mem_req_addr, mem_req_valid); end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hDEAD_BEEF;
    tick();
    mem_resp_valid = 0;
    total++; if (out_valid !== 1'b1 || out_rdata !== 32'h0 || out_err !== 1'b0) begin
      bad++; $display("FAIL sh_result got ov=%b d=%h e=%b want 1/0/0", out_valid, out_rdata, out_err); end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_bad_requests();
    logic seen_req;
    seen_req = 0;
    in_valid = 1; in_ren = 1; in_funct3 = 3'b010; in_addr = 32'h8000_0002;
    mem_req_ready = 1;
    tick();
    in_valid = 0; in_ren = 0;
    seen_req |= mem_req_valid;
    total++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_rdata !== 32'h0) begin
      bad++; $display("FAIL misal_lw got ov=%b e=%b d=%h want 1/1/0", out_valid, out_err, out_rdata); end
    out_ready = 1;
    tick();
    seen_req |= mem_req_valid;
    // ld is illegal on RV32 even when aligned
    in_valid = 1; in_ren = 1; in_funct3 = 3'b011; in_addr = 32'h8000_0008;
    tick();
    in_valid = 0; in_ren = 0;
    seen_req |= mem_req_valid;
    total++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin bad++; $display("FAIL ld_rv32 got ov=%b e=%b want 1/1", out_valid, out_err); end
    tick();
    // neither load nor store: completes without error
    in_valid = 1; in_funct3 = 3'b111; in_addr = 32'h8000_0001;
    tick();
    in_valid = 0;
    seen_req |= mem_req_valid;
    total++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_rdata !== 32'h0) begin
      bad++; $display("FAIL noop got ov=%b e=%b d=%h want 1/0/0", out_valid, out_err, out_rdata); end
    tick();
    out_ready = 0; mem_req_ready = 0;
    total++; if (seen_req !== 1'b0) begin bad++; $display("FAIL bad_no_bus got=%b want=0", seen_req); end
  endtask

  task automatic test_bus_stall_err();
    logic stable;
    stable = 1;
    in_valid = 1; in_ren = 1; in_funct3 = 3'b010; in_addr = 32'h8000_0010;
    tick();
    in_valid = 0; in_ren = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0010 || mem_req_we !== 1'b0 || mem_req_wstrb !== 4'b0)
        stable = 0;
      tick();
    end
    mem_req_ready = 1;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0010) stable = 0;
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL stall_payload got=%b want=1", stable); end
    tick();
    mem_req_ready = 0;
    stable = 1;
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) stable = 0;
      tick();
    end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL stall_wait got=%b want=1", stable); end
    mem_resp_valid = 1; mem_resp_err = 1; mem_resp_rdata = 32'h1234_5678;
    tick();
    mem_resp_valid = 0; mem_resp_err = 0;
    total++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_rdata !== 32'h0) begin
      bad++; $display("FAIL bus_err got ov=%b e=%b d=%h want 1/1/0", out_valid, out_err, out_rdata); end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_out_backpressure();
    logic stable;
    stable = 1;
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_AB00;
    in_valid = 1; in_ren = 1; in_funct3 = 3'b100; in_addr = 32'h0000_0101;
    tick();
    in_valid = 0; in_ren = 0;
    tick();
    tick();
    mem_req_ready = 0; mem_resp_valid = 0;
    for (int i = 0; i < 5; i++) begin
      mem_resp_rdata = 32'hFFFF_FFFF;
      if (out_valid !== 1'b1 || out_rdata !== 32'h0000_00AB || in_ready !== 1'b0) stable = 0;
      tick();
    end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL hold_done got=%b want=1 (rdata=%h)", stable, out_rdata); end
    out_ready = 1;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL hs_cycle got ir=%b ov=%b want 0/1", in_ready, out_valid); end
    tick();
    out_ready = 0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL after_hs got ir=%b ov=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid();
    mem_req_ready = 1;
    in_valid = 1; in_ren = 1; in_funct3 = 3'b010; in_addr = 32'h0000_0200;
    tick();
    in_valid = 0; in_ren = 0;
    tick();
    mem_req_ready = 0;
    total++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL in_wait got req=%b ov=%b ir=%b want 0/0/0", mem_req_valid, out_valid, in_ready); end
    rst = 1;
    tick();
    rst = 0;
    mem_resp_valid = 1; mem_resp_rdata = 32'hFFFF_FFFF; mem_resp_err = 1;
    tick();
    mem_resp_valid = 0; mem_resp_err = 0;
    tick();
    total++; if (out_valid !== 1'b0 || out_rdata !== 32'h0 || out_err !== 1'b0 || in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL stray_resp got ov=%b d=%h e=%b ir=%b rv=%b want 0/0/0/1/0",
                      out_valid, out_rdata, out_err, in_ready, mem_req_valid); end
  endtask

  task automatic test_rv64();
    w_mem_req_ready = 1; w_mem_resp_valid = 1; w_mem_resp_rdata = 64'h0123_4567_89AB_CDEF;
    w_in_valid = 1; w_in_ren = 1; w_in_funct3 = 3'b011; w_in_addr = 32'h0000_0008;
    tick();
    w_in_valid = 0; w_in_ren = 0;
    total++; if (w_mem_req_addr !== 32'h8 || w_mem_req_wstrb !== 8'h00 || w_mem_req_valid !== 1'b1) begin
      bad++; $display("FAIL ld_req got a=%h s=%b v=%b want 8/00000000/1", w_mem_req_addr, w_mem_req_wstrb, w_mem_req_valid); end
    tick();
    tick();
    total++; if (w_out_valid !== 1'b1 || w_out_rdata !== 64'h0123_4567_89AB_CDEF || w_out_err !== 1'b0) begin
      bad++; $display("FAIL ld64 got ov=%b d=%h e=%b want 1/0123456789abcdef/0", w_out_valid, w_out_rdata, w_out_err); end
    w_out_ready = 1;
    tick();
    w_out_ready = 0;
    w_mem_resp_rdata = 64'hFFFF_FFFF_0000_0000;
    w_in_valid = 1; w_in_ren = 1; w_in_funct3 = 3'b110; w_in_addr = 32'h0000_0004;
    tick();
    w_in_valid = 0; w_in_ren = 0;
    total++; if (w_mem_req_addr !== 32'h0) begin bad++; $display("FAIL lwu_addr got=%h want=0", w_mem_req_addr); end
    tick();
    tick();
    total++; if (w_out_valid !== 1'b1 || w_out_rdata !== 64'h0000_0000_FFFF_FFFF) begin
      bad++; $display("FAIL lwu64 got ov=%b d=%h want 1/00000000ffffffff", w_out_valid, w_out_rdata); end
    w_out_ready = 1;
    tick();
    w_out_ready = 0;
    // sd at offset 0 drives all eight lanes
    w_in_valid = 1; w_in_wen = 1; w_in_funct3 = 3'b011; w_in_addr = 32'h0000_0010; w_in_wdata = 64'hA5A5_0000_1111_2222;
    tick();
    w_in_valid = 0; w_in_wen = 0;
    total++; if (w_mem_req_wstrb !== 8'hFF || w_mem_req_wdata !== 64'hA5A5_0000_1111_2222 || w_mem_req_we !== 1'b1) begin
      bad++; $display("FAIL sd64 got s=%b d=%h we=%b want 11111111/a5a5000011112222/1", w_mem_req_wstrb, w_mem_req_wdata, w_mem_req_we); end
    tick();
    tick();
    w_mem_req_ready = 0; w_mem_resp_valid = 0;
    w_out_ready = 1;
    tick();
    w_out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_bad_requests();
    test_bus_stall_err();
    test_out_backpressure();
    test_reset_mid();
    test_rv64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus.md
Name: lsu_bus

Overview:
- Multi-cycle load/store unit for the NPC core. Replaces the single-cycle combinational LSU that calls the DPI memory directly.
- Accepts one memory operation at a time from EXU over a valid/ready handshake. Issues it on a simple request/response memory bus with byte strobes, then returns the extended load data or an error to WBU over a second valid/ready handshake.
- Parametrised in data width (RV32/RV64). Adds misalignment and bus-error reporting.

Parameters:
- XLEN, 32, data/register width; legal values 32 or 64. NB = XLEN/8 bytes, OFS_W = log2(NB).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EXU request valid
- in_ready  out  1  LSU can accept a request
- in_ren  in  1  load
- in_wen  in  1  store
- in_funct3  in  3  RISC-V size/sign field
- in_addr  in  ADDR_W  byte address
- in_wdata  in  XLEN  store data, right-aligned
- out_valid  out  1  result valid to WBU
- out_ready  in  1  WBU accepts result
- out_rdata  out  XLEN  extended load data; 0 for stores/errors
- out_err  out  1  misaligned, illegal funct3, or bus error
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_we  out  1  write request
- mem_req_addr  out  ADDR_W  NB-aligned address (low OFS_W bits zero)
- mem_req_wdata  out  XLEN  lane-shifted store data
- mem_req_wstrb  out  NB  byte write strobes; all 0 on reads
- mem_resp_valid  in  1  bus response valid (reads and writes)
- mem_resp_rdata  in  XLEN  full bus word
- mem_resp_err  in  1  bus error

Behaviour:
- Clock/reset: single clock clk. rst is synchronous and active-high.
- Reset values: state IDLE. out_valid=0, out_rdata=0, out_err=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wstrb=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation: rst in any state returns the FSM to IDLE and drops all valids. A bus response arriving later is ignored.
- FSM states: IDLE, REQ, WAIT, DONE. in_ready = (state==IDLE).
- IDLE, on in_valid&in_ready: latch all inputs, then decode:
  - Neither ren nor wen: go to DONE, rdata=0, err=0.
  - ren and wen both set, illegal funct3, or misaligned: go to DONE, err=1, rdata=0. No bus access.
  - Otherwise: go to REQ.
- Legal funct3:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; 110 lwu and 011 ld only when XLEN=64.
  - Stores: 000 sb, 001 sh, 010 sw; 011 sd only when XLEN=64.
- Alignment: size 2 requires addr[0]=0; size 4 requires addr[1:0]=0; size 8 requires addr[2:0]=0.
- REQ:
  - mem_req_valid=1. Payload is held stable until mem_req_valid&mem_req_ready, then go to WAIT.
  - ofs = addr[OFS_W-1:0].
  - mem_req_wdata = in_wdata << (8*ofs), truncated to XLEN.
  - mem_req_wstrb = ((1<<size)-1) << ofs.
- WAIT:
  - mem_resp_valid is sampled only in WAIT; a response in any other state is ignored.
  - On response, capture err = mem_resp_err.
  - For a load without error: rdata = extend((mem_resp_rdata >> 8*ofs), size, signed).
  - For a store or an error: rdata = 0.
  - Then go to DONE.
- DONE: out_valid=1 with rdata/err held until out_ready; then go to IDLE. No new request is accepted in that same cycle.
- Minimum latency with a zero-wait bus (accept edge = cycle 0):
  - REQ in cycle 1 with ready=1; WAIT in cycle 2 with resp=1; out_valid in cycle 3.
  - Error or no-op requests: out_valid in cycle 1.

Test Plan:
- XLEN=32, lb at 0x8000_0003 with mem_resp_rdata=0x80FF_1234 -> mem_req_addr=0x8000_0000, wstrb=0000; out_rdata=0xFFFF_FF80, out_err=0; out_valid exactly 3 cycles after accept.
- XLEN=32, sh at 0x8000_0002 with wdata=0x1234_ABCD -> mem_req_wdata=0xABCD_0000, wstrb=1100, we=1; out_rdata=0 after the response.
- lw at 0x8000_0002 -> out_err=1 one cycle after accept; mem_req_valid never asserts.
- mem_req_ready low 4 cycles, then high; response delayed 3 cycles with mem_resp_err=1 -> request payload stable throughout; out_err=1, out_rdata=0.
- out_ready held low 5 cycles in DONE -> out_valid/out_rdata stable; in_ready=0 until the cycle after the handshake.
- rst asserted in WAIT, then a stray mem_resp_valid -> outputs stay 0, in_ready=1. XLEN=64 ld at 0x8 returns the full 64-bit word; lwu at 0x4 of 0xFFFF_FFFF_0000_0000 returns 0x0000_0000_FFFF_FFFF.
